decode_stage_pipe: RTL and testbench
====================================

Name: decode_stage_pipe

Overview:
Parametrised ID stage for the 5-stage MIPS pipeline, successor to the original combinational decode block.
- Integrates the register file, control decode and sign-extend.
- Resolves branches and jumps in ID, with MEM forwarding and WB write-through.
- Detects load-use and branch-operand hazards and generates the stall.
- Owns the registered ID/EX pipeline register, with bubble insertion.
- Sits between the IF/ID register and the EX stage.

Parameters:
- WIDTH, 32, datapath and register width.
- RADDR_W, 5, register address width; register count is 2**RADDR_W, with r0 hardwired to zero.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- instr_id  in  WIDTH  instruction from IF/ID
- pc4_id  in  WIDTH  PC+4 from IF/ID
- valid_id  in  1  IF/ID holds a real instruction
- regaddr_ex, regaddr_mem, regaddr_wb  in  RADDR_W  destination register per stage
- regwrite_ex, regwrite_mem, regwrite_wb  in  1  write enable per stage
- memtoreg_ex, memtoreg_mem  in  1  load in EX / MEM
- aluout_mem  in  WIDTH  MEM ALU result
- result_wb  in  WIDTH  WB write data
- stall_if  out  1  hold PC and IF/ID
- flush_if  out  1  clear IF/ID
- pcsrc  out  1  redirect PC
- pc_target  out  WIDTH  branch/jump target
- ex_valid, ex_regwrite, ex_memtoreg, ex_memwrite, ex_alusrc  out  1  registered controls
- ex_alucontrol  out  4  registered ALU op
- ex_data1, ex_data2, ex_imm  out  WIDTH  registered operands and sign-extended immediate
- ex_rs, ex_rt, ex_dst  out  RADDR_W  registered register addresses (ex_dst is after regdst select)
- ex_shamt  out  5  registered shift amount

Behaviour:
- Reset (rst=0 at posedge):
  - All ex_* outputs are 0; all registers are 0.
  - Combinational outputs are forced to 0 while rst=0.
- Supported decode: R-type add/sub/and/or/slt/sll/srl, lw, sw, addi, beq, bne, j.
  - Any other opcode decodes as a NOP: all controls 0, ex_valid=0.
- Register file:
  - Two async reads, one sync write on posedge when regwrite_wb and regaddr_wb != 0.
  - Writes to r0 are ignored; r0 always reads 0.
  - WB write-through: a same-cycle read of regaddr_wb returns result_wb (except r0).
- Branch operand select, per operand:
  - If regwrite_mem, !memtoreg_mem, regaddr_mem != 0 and address matches → aluout_mem.
  - Otherwise → register-file value.
- Load-use stall: ex is a load (memtoreg_ex & regwrite_ex), regaddr_ex != 0, and it matches rs, or rt when rt is a source.
  - rt is a source for R-type, sw, beq, bne.
- Branch stall: instruction is beq/bne and either:
  - EX writes rs/rt (regwrite_ex, regaddr_ex != 0), or
  - MEM is a load writing rs/rt.
- stall_if = valid_id & (load-use | branch stall).
  - While stalled: ID/EX captures a bubble (all controls 0, ex_valid=0); IF/ID and PC hold.
- Branch resolution (same cycle, combinational):
  - pcsrc = valid_id & !stall_if & ((beq & eq) | (bne & !eq) | j).
  - beq/bne target: pc4_id + (sext(imm16) << 2), computed modulo 2**WIDTH.
  - j target: {pc4_id[WIDTH-1:28], instr[25:0], 2'b00}.
  - flush_if = pcsrc.
  - The branch itself proceeds to EX as a no-write instruction; j proceeds as a NOP.
- ID/EX register:
  - On each posedge, loads decoded fields, or a bubble when stall_if or !valid_id.
  - Latency is one cycle from ID to ex_*.
- Stall and taken branch in the same cycle: stall wins, pcsrc=0; the branch re-resolves next cycle.
- Reset asserted mid-stall: the stall clears and the pipeline register is zeroed.

Optional Feature:
- Macro: DECODE_PERF_CNT_EN.
- When defined, adds three 32-bit outputs:
  - perf_stall: cycles with stall_if=1.
  - perf_taken: cycles with pcsrc=1.
  - perf_instr: valid non-bubble loads into ID/EX.
- Counters clear on reset and saturate at 2**32-1.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package decode_pkg holds:
  - opcode/funct localparams;
  - 4-bit ALU control codes (ADD=0010, SUB=0110, AND=0000, OR=0001, SLT=0111, SLL=1000, SRL=1001);
  - the ID/EX bundle field order.
- One sub-module: decode_regfile (parametrised register file with write-through).
- Hazard, forwarding and control logic stay inline.

Test Plan:
- Reset with rst=0 for 2 cycles → all ex_* = 0, stall_if=0, pcsrc=0; a read of r5 returns 0.
- WB writes r3=0x0000_00AA while ID reads r3 in the same cycle via add → next cycle ex_data1=0x0000_00AA. A WB write to r0 of 0xFFFF_FFFF → r0 still reads 0.
- lw r2 in EX, then add r4,r2,r1 in ID → stall_if=1 for exactly 1 cycle and ex_valid=0 bubble; next cycle the add issues with ex_valid=1.
- beq r1,r2 at pc4=0x104 with imm=0x0003, r1=r2=7 → pcsrc=1, flush_if=1, pc_target=0x110. Same with bne → pcsrc=0.
- beq with rs produced by an ALU op in MEM (aluout_mem=9) and rt=9 → forwarded, no stall, pcsrc=1. Producer in EX instead → 1 stall, then resolves taken.
- j with instr[25:0]=0x0000040, pc4=0x8000_0010 → pc_target=0x8000_0100, pcsrc=1. With DECODE_PERF_CNT_EN defined, perf_taken increments by 1.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared definitions for the ID stage: opcode/funct encodings, ALU control
// codes, the ID/EX control bundle and the primary control decoder.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;

  // ID/EX bundle field order: ctrl, rs, rt, dst, shamt, data1, data2, imm.
  // The control part is shared through this struct; the data part is sized
  // by the stage's WIDTH/RADDR_W parameters.
  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic [3:0] alucontrol;
  } ctrl_t;

  // Unsupported opcodes (and j, which needs nothing in EX) decode to all-zero.
  function automatic ctrl_t decode_ctrl(input logic [5:0] op, input logic [5:0] funct);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.valid    = 1'b1;
        c.regwrite = 1'b1;
        case (funct)
          FN_ADD:  c.alucontrol = ALU_ADD;
          FN_SUB:  c.alucontrol = ALU_SUB;
          FN_AND:  c.alucontrol = ALU_AND;
          FN_OR:   c.alucontrol = ALU_OR;
          FN_SLT:  c.alucontrol = ALU_SLT;
          FN_SLL:  c.alucontrol = ALU_SLL;
          FN_SRL:  c.alucontrol = ALU_SRL;
          default: c = '0;
        endcase
      end
      OP_LW: begin
        c.valid = 1'b1; c.regwrite = 1'b1; c.memtoreg = 1'b1;
        c.alusrc = 1'b1; c.alucontrol = ALU_ADD;
      end
      OP_SW: begin
        c.valid = 1'b1; c.memwrite = 1'b1; c.alusrc = 1'b1; c.alucontrol = ALU_ADD;
      end
      OP_ADDI: begin
        c.valid = 1'b1; c.regwrite = 1'b1; c.alusrc = 1'b1; c.alucontrol = ALU_ADD;
      end
      OP_BEQ, OP_BNE: begin
        c.valid = 1'b1; c.alucontrol = ALU_SUB;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Register file for the ID stage: two async reads, one sync write, r0 tied
// to zero, and write-through of the same-cycle WB write onto the read ports.
module decode_regfile #(
  parameter int WIDTH   = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RADDR_W-1:0] raddr1_i,
  input  logic [RADDR_W-1:0] raddr2_i,
  input  logic               we_i,
  input  logic [RADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]   wdata_i,
  output logic [WIDTH-1:0]   rdata1_o,
  output logic [WIDTH-1:0]   rdata2_o
);

  localparam int NREGS = 2**RADDR_W;

  logic [WIDTH-1:0] regs_q [NREGS];

  // Clear all registers on reset; otherwise write WB data, never into r0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && waddr_i != '0) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports: r0 is zero, a matching WB write bypasses the array.
  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    rdata2_o = regs_q[raddr2_i];
    if (raddr1_i == '0)                        rdata1_o = '0;
    else if (we_i && raddr1_i == waddr_i)      rdata1_o = wdata_i;
    if (raddr2_i == '0)                        rdata2_o = '0;
    else if (we_i && raddr2_i == waddr_i)      rdata2_o = wdata_i;
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// ID stage of the 5-stage MIPS pipeline: register file, control decode,
// branch/jump resolution with MEM forwarding, hazard stall, and the ID/EX
// pipeline register. Define DECODE_PERF_CNT_EN to add the perf counters.
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   instr_id,
  input  logic [WIDTH-1:0]   pc4_id,
  input  logic               valid_id,
  input  logic [RADDR_W-1:0] regaddr_ex,
  input  logic [RADDR_W-1:0] regaddr_mem,
  input  logic [RADDR_W-1:0] regaddr_wb,
  input  logic               regwrite_ex,
  input  logic               regwrite_mem,
  input  logic               regwrite_wb,
  input  logic               memtoreg_ex,
  input  logic               memtoreg_mem,
  input  logic [WIDTH-1:0]   aluout_mem,
  input  logic [WIDTH-1:0]   result_wb,
  output logic               stall_if,
  output logic               flush_if,
  output logic               pcsrc,
  output logic [WIDTH-1:0]   pc_target,
  output logic               ex_valid,
  output logic               ex_regwrite,
  output logic               ex_memtoreg,
  output logic               ex_memwrite,
  output logic               ex_alusrc,
  output logic [3:0]         ex_alucontrol,
  output logic [WIDTH-1:0]   ex_data1,
  output logic [WIDTH-1:0]   ex_data2,
  output logic [WIDTH-1:0]   ex_imm,
  output logic [RADDR_W-1:0] ex_rs,
  output logic [RADDR_W-1:0] ex_rt,
  output logic [RADDR_W-1:0] ex_dst,
  output logic [4:0]         ex_shamt
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]        perf_stall,
  output logic [31:0]        perf_taken,
  output logic [31:0]        perf_instr
`endif
);

  logic [5:0]              op, funct;
  logic [RADDR_W-1:0]      rs, rt, rd;
  ctrl_t                   ctrl;
  logic                    is_rtype, is_sw, is_br, is_beq, is_bne, is_j;
  logic [WIDTH-1:0]        rd1, rd2, bop1, bop2;
  logic signed [WIDTH-1:0] imm_sext;
  logic [WIDTH-1:0]        br_target, j_target;
  logic                    rt_src, ex_load, ex_wr, mem_load, mem_fwd;
  logic                    load_use, br_hazard, stall, taken;

  assign op       = instr_id[31:26];
  assign funct    = instr_id[5:0];
  assign rs       = RADDR_W'(instr_id[25:21]);
  assign rt       = RADDR_W'(instr_id[20:16]);
  assign rd       = RADDR_W'(instr_id[15:11]);
  assign ctrl     = decode_ctrl(op, funct);
  assign is_rtype = (op == OP_RTYPE);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);
  assign is_bne   = (op == OP_BNE);
  assign is_br    = is_beq | is_bne;
  assign is_j     = (op == OP_J);

  decode_regfile #(.WIDTH(WIDTH), .RADDR_W(RADDR_W)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .we_i     (regwrite_wb),
    .waddr_i  (regaddr_wb),
    .wdata_i  (result_wb),
    .rdata1_o (rd1),
    .rdata2_o (rd2)
  );

  // Branch operands: an ALU result sitting in MEM is forwarded; a load in MEM
  // or any producer in EX is not available yet and forces a stall instead.
  assign mem_fwd = regwrite_mem & ~memtoreg_mem & (regaddr_mem != '0);
  assign bop1    = (mem_fwd && regaddr_mem == rs) ? aluout_mem : rd1;
  assign bop2    = (mem_fwd && regaddr_mem == rt) ? aluout_mem : rd2;

  assign rt_src    = is_rtype | is_sw | is_br;
  assign ex_load   = memtoreg_ex & regwrite_ex & (regaddr_ex != '0);
  assign ex_wr     = regwrite_ex & (regaddr_ex != '0);
  assign mem_load  = regwrite_mem & memtoreg_mem & (regaddr_mem != '0);
  assign load_use  = ex_load & ((regaddr_ex == rs) | (rt_src & (regaddr_ex == rt)));
  assign br_hazard = is_br & ((ex_wr & ((regaddr_ex == rs) | (regaddr_ex == rt))) |
                              (mem_load & ((regaddr_mem == rs) | (regaddr_mem == rt))));
  assign stall     = rst & valid_id & (load_use | br_hazard);

  // A stall always beats a taken branch; the branch re-resolves next cycle.
  assign taken = rst & valid_id & ~stall &
                 ((is_beq & (bop1 == bop2)) | (is_bne & (bop1 != bop2)) | is_j);

  assign imm_sext  = {{(WIDTH-16){instr_id[15]}}, instr_id[15:0]};
  assign br_target = pc4_id + {imm_sext[WIDTH-3:0], 2'b00};
  assign j_target  = {pc4_id[WIDTH-1:28], instr_id[25:0], 2'b00};

  assign stall_if  = stall;
  assign pcsrc     = taken;
  assign flush_if  = taken;
  assign pc_target = rst ? (is_j ? j_target : br_target) : '0;

  ctrl_t              ctrl_d, ctrl_q;
  logic [RADDR_W-1:0] rs_d, rt_d, dst_d, rs_q, rt_q, dst_q;
  logic [4:0]         shamt_d, shamt_q;
  logic [WIDTH-1:0]   data1_d, data2_d, imm_d, data1_q, data2_q, imm_q;

  // ID/EX next state: decoded fields, or an all-zero bubble on stall/NOP/empty slot.
  always_comb begin
    ctrl_d  = '0;
    rs_d    = '0;
    rt_d    = '0;
    dst_d   = '0;
    shamt_d = '0;
    data1_d = '0;
    data2_d = '0;
    imm_d   = '0;
    if (valid_id && !stall && ctrl.valid) begin
      ctrl_d  = ctrl;
      rs_d    = rs;
      rt_d    = rt;
      dst_d   = is_rtype ? rd : rt;
      shamt_d = instr_id[10:6];
      data1_d = rd1;
      data2_d = rd2;
      imm_d   = imm_sext;
    end
  end

  // ID/EX pipeline register, zeroed on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q  <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      dst_q   <= '0;
      shamt_q <= '0;
      data1_q <= '0;
      data2_q <= '0;
      imm_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      dst_q   <= dst_d;
      shamt_q <= shamt_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      imm_q   <= imm_d;
    end
  end

  assign ex_valid      = ctrl_q.valid;
  assign ex_regwrite   = ctrl_q.regwrite;
  assign ex_memtoreg   = ctrl_q.memtoreg;
  assign ex_memwrite   = ctrl_q.memwrite;
  assign ex_alusrc     = ctrl_q.alusrc;
  assign ex_alucontrol = ctrl_q.alucontrol;
  assign ex_rs         = rs_q;
  assign ex_rt         = rt_q;
  assign ex_dst        = dst_q;
  assign ex_shamt      = shamt_q;
  assign ex_data1      = data1_q;
  assign ex_data2      = data2_q;
  assign ex_imm        = imm_q;

`ifdef DECODE_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] perf_stall_q, perf_taken_q, perf_instr_q;

  // Saturating event counters for stalls, taken redirects and issued instructions.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_taken_q <= '0;
      perf_instr_q <= '0;
    end else begin
      if (stall)        perf_stall_q <= sat_inc(perf_stall_q);
      if (taken)        perf_taken_q <= sat_inc(perf_taken_q);
      if (ctrl_d.valid) perf_instr_q <= sat_inc(perf_instr_q);
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_taken = perf_taken_q;
  assign perf_instr = perf_instr_q;
`endif

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Self-checking bench for decode_stage_pipe: directed literal cases followed
// by randomized traffic against an instruction-level reference model.
module tb_decode_stage_pipe;

  localparam int WIDTH = 32;
  localparam int RADDR_W = 5;

  localparam logic [5:0] T_LW = 6'h23, T_SW = 6'h2B, T_ADDI = 6'h08;
  localparam logic [5:0] T_BEQ = 6'h04, T_BNE = 6'h05, T_J = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A, F_SLL = 6'h00, F_SRL = 6'h02;

  localparam int M_ADD = 0, M_SUB = 1, M_AND = 2, M_OR = 3, M_SLT = 4, M_SLL = 5, M_SRL = 6;
  localparam int M_LW = 7, M_SW = 8, M_ADDI = 9, M_BEQ = 10, M_BNE = 11, M_J = 12, M_NOP = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [31:0]       instr_id, pc4_id, aluout_mem, result_wb;
  logic              valid_id;
  logic [4:0]        regaddr_ex, regaddr_mem, regaddr_wb;
  logic              regwrite_ex, regwrite_mem, regwrite_wb, memtoreg_ex, memtoreg_mem;
  logic              stall_if, flush_if, pcsrc;
  logic [31:0]       pc_target;
  logic              ex_valid, ex_regwrite, ex_memtoreg, ex_memwrite, ex_alusrc;
  logic [3:0]        ex_alucontrol;
  logic [31:0]       ex_data1, ex_data2, ex_imm;
  logic [4:0]        ex_rs, ex_rt, ex_dst, ex_shamt;
`ifdef DECODE_PERF_CNT_EN
  logic [31:0]       perf_stall, perf_taken, perf_instr;
`endif

  decode_stage_pipe #(.WIDTH(WIDTH), .RADDR_W(RADDR_W)) dut (
    .clk(clk), .rst(rst), .instr_id(instr_id), .pc4_id(pc4_id), .valid_id(valid_id),
    .regaddr_ex(regaddr_ex), .regaddr_mem(regaddr_mem), .regaddr_wb(regaddr_wb),
    .regwrite_ex(regwrite_ex), .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb),
    .memtoreg_ex(memtoreg_ex), .memtoreg_mem(memtoreg_mem),
    .aluout_mem(aluout_mem), .result_wb(result_wb),
    .stall_if(stall_if), .flush_if(flush_if), .pcsrc(pcsrc), .pc_target(pc_target),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc), .ex_alucontrol(ex_alucontrol),
    .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst), .ex_shamt(ex_shamt)
`ifdef DECODE_PERF_CNT_EN
    , .perf_stall(perf_stall), .perf_taken(perf_taken), .perf_instr(perf_instr)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        valid, regwrite, memtoreg, memwrite, alusrc;
    logic [3:0]  alu;
    logic [4:0]  rs, rt, dst, shamt;
    logic [31:0] d1, d2, imm;
  } ex_t;

  // ---------------- reference model ----------------
  logic [31:0] rf [32];
  ex_t         exp_ex, nxt_ex = '0, act_ex;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_a = '0;
  logic [31:0] wb_d = '0;
  logic        m_rst = 1'b0;
  logic [31:0] m_pstall = '0, m_ptaken = '0, m_pinstr = '0;
  logic [31:0] n_pstall = '0, n_ptaken = '0, n_pinstr = '0;

  function automatic int classify(input logic [31:0] ins);
    case (ins[31:26])
      6'h00: case (ins[5:0])
        F_ADD: return M_ADD;  F_SUB: return M_SUB;  F_AND: return M_AND;
        F_OR:  return M_OR;   F_SLT: return M_SLT;  F_SLL: return M_SLL;
        F_SRL: return M_SRL;  default: return M_NOP;
      endcase
      T_LW:   return M_LW;
      T_SW:   return M_SW;
      T_ADDI: return M_ADDI;
      T_BEQ:  return M_BEQ;
      T_BNE:  return M_BNE;
      T_J:    return M_J;
      default: return M_NOP;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input int m);
    case (m)
      M_SUB, M_BEQ, M_BNE: return 4'b0110;
      M_AND: return 4'b0000;
      M_OR:  return 4'b0001;
      M_SLT: return 4'b0111;
      M_SLL: return 4'b1000;
      M_SRL: return 4'b1001;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic logic [31:0] rdreg(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (regwrite_wb && regaddr_wb == a) return result_wb;
    return rf[a];
  endfunction

  function automatic logic [31:0] bopnd(input logic [4:0] a);
    if (regwrite_mem && !memtoreg_mem && regaddr_mem != 0 && regaddr_mem == a) return aluout_mem;
    return rdreg(a);
  endfunction

  function automatic logic [31:0] sat1(input logic [31:0] v, input logic inc);
    if (!inc || v == 32'hFFFF_FFFF) return v;
    return v + 1;
  endfunction

  int          m;
  logic [4:0]  rs, rt, rd;
  logic        is_br, rt_src, load_use, br_haz, e_stall, e_pcsrc;
  logic [31:0] a_op, b_op, e_tgt;
  int          imm_int;

  // Compare process: evaluates the model for the current cycle and checks the DUT.
  always @(negedge clk) begin
    m = classify(instr_id);
    rs = instr_id[25:21]; rt = instr_id[20:16]; rd = instr_id[15:11];
    imm_int = $signed(instr_id[15:0]);
    is_br  = (m == M_BEQ) || (m == M_BNE);
    rt_src = (instr_id[31:26] == 6'h00) || (m == M_SW) || is_br;
    load_use = memtoreg_ex && regwrite_ex && regaddr_ex != 0 &&
               (regaddr_ex == rs || (rt_src && regaddr_ex == rt));
    br_haz = is_br && ((regwrite_ex && regaddr_ex != 0 && (regaddr_ex == rs || regaddr_ex == rt)) ||
                       (regwrite_mem && memtoreg_mem && regaddr_mem != 0 &&
                        (regaddr_mem == rs || regaddr_mem == rt)));
    e_stall = rst && valid_id && (load_use || br_haz);
    a_op = bopnd(rs);
    b_op = bopnd(rt);
    e_pcsrc = rst && valid_id && !e_stall &&
              ((m == M_BEQ && a_op == b_op) || (m == M_BNE && a_op != b_op) || m == M_J);
    e_tgt = (m == M_J) ? {pc4_id[31:28], instr_id[25:0], 2'b00} : pc4_id + 32'(imm_int * 4);

    check("stall_if", {31'd0, stall_if}, {31'd0, e_stall});
    check("pcsrc", {31'd0, pcsrc}, {31'd0, e_pcsrc});
    check("flush_if", {31'd0, flush_if}, {31'd0, e_pcsrc});
    if (e_pcsrc)   check("pc_target", pc_target, e_tgt);
    else if (!rst) check("pc_target_rst", pc_target, 32'd0);

    act_ex = '{valid: ex_valid, regwrite: ex_regwrite, memtoreg: ex_memtoreg, memwrite: ex_memwrite,
               alusrc: ex_alusrc, alu: ex_alucontrol, rs: ex_rs, rt: ex_rt, dst: ex_dst,
               shamt: ex_shamt, d1: ex_data1, d2: ex_data2, imm: ex_imm};
    n_checks++;
    if (act_ex !== exp_ex) begin
      n_fail++;
      $display("FAIL idex_bundle: actual %h required %h at %0t", act_ex, exp_ex, $time);
    end
`ifdef DECODE_PERF_CNT_EN
    check("perf_stall", perf_stall, m_pstall);
    check("perf_taken", perf_taken, m_ptaken);
    check("perf_instr", perf_instr, m_pinstr);
`endif

    nxt_ex = '0;
    if (rst && valid_id && !e_stall && m != M_J && m != M_NOP) begin
      nxt_ex.valid    = 1'b1;
      nxt_ex.regwrite = (m <= M_SRL) || m == M_LW || m == M_ADDI;
      nxt_ex.memtoreg = (m == M_LW);
      nxt_ex.memwrite = (m == M_SW);
      nxt_ex.alusrc   = (m == M_LW) || (m == M_SW) || (m == M_ADDI);
      nxt_ex.alu      = alu_of(m);
      nxt_ex.rs       = rs;
      nxt_ex.rt       = rt;
      nxt_ex.dst      = (m <= M_SRL) ? rd : rt;
      nxt_ex.shamt    = instr_id[10:6];
      nxt_ex.d1       = rdreg(rs);
      nxt_ex.d2       = rdreg(rt);
      nxt_ex.imm      = 32'(imm_int);
    end
    m_rst = !rst;
    wb_we = rst && regwrite_wb && regaddr_wb != 0;
    wb_a  = regaddr_wb;
    wb_d  = result_wb;
    n_pstall = rst ? sat1(m_pstall, e_stall) : 32'd0;
    n_ptaken = rst ? sat1(m_ptaken, e_pcsrc) : 32'd0;
    n_pinstr = rst ? sat1(m_pinstr, nxt_ex.valid) : 32'd0;
  end

  // Model state update on the active edge.
  always @(posedge clk) begin
    exp_ex   <= nxt_ex;
    m_pstall <= n_pstall;
    m_ptaken <= n_ptaken;
    m_pinstr <= n_pinstr;
    if (m_rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (wb_we) begin
      rf[wb_a] <= wb_d;
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [4:0] sh);
    return {6'h00, s, t, d, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                                        input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  s, t, d;
    logic [31:0] r;
    s = 5'($urandom_range(0, 7));
    t = 5'($urandom_range(0, 7));
    d = 5'($urandom_range(0, 7));
    r = $urandom();
    case ($urandom_range(0, 13))
      0:  return enc_r(F_ADD, s, t, d, r[20:16]);
      1:  return enc_r(F_SUB, s, t, d, r[20:16]);
      2:  return enc_r(F_AND, s, t, d, r[20:16]);
      3:  return enc_r(F_OR,  s, t, d, r[20:16]);
      4:  return enc_r(F_SLT, s, t, d, r[20:16]);
      5:  return enc_r(F_SLL, s, t, d, r[20:16]);
      6:  return enc_r(F_SRL, s, t, d, r[20:16]);
      7:  return enc_i(T_LW,   s, t, r[15:0]);
      8:  return enc_i(T_SW,   s, t, r[15:0]);
      9:  return enc_i(T_ADDI, s, t, r[15:0]);
      10: return enc_i(T_BEQ,  s, t, r[15:0]);
      11: return enc_i(T_BNE,  s, t, r[15:0]);
      12: return {T_J, r[25:0]};
      default: return {6'h3F, r[25:0]};
    endcase
  endfunction

  task automatic idle();
    instr_id = 32'd0; pc4_id = 32'd0; valid_id = 1'b0;
    regaddr_ex = 0; regaddr_mem = 0; regaddr_wb = 0;
    regwrite_ex = 0; regwrite_mem = 0; regwrite_wb = 0;
    memtoreg_ex = 0; memtoreg_mem = 0;
    aluout_mem = 32'd0; result_wb = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    step(); step();
    check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_ex_data1", ex_data1, 32'd0);
    check("rst_stall", {31'd0, stall_if}, 32'd0);
    check("rst_pcsrc", {31'd0, pcsrc}, 32'd0);

    rst = 1'b1; valid_id = 1'b1; instr_id = enc_r(F_ADD, 5'd5, 5'd0, 5'd6, 5'd0);
    step();
    check("r5_reads_zero", ex_data1, 32'd0);
    check("add_ex_valid", {31'd0, ex_valid}, 32'd1);

    regwrite_wb = 1; regaddr_wb = 5'd3; result_wb = 32'h0000_00AA;
    instr_id = enc_r(F_ADD, 5'd3, 5'd0, 5'd4, 5'd0);
    step();
    check("wb_write_through", ex_data1, 32'h0000_00AA);
    regaddr_wb = 5'd0; result_wb = 32'hFFFF_FFFF;
    instr_id = enc_r(F_ADD, 5'd0, 5'd3, 5'd5, 5'd0);
    step();
    check("r0_wt_zero", ex_data1, 32'd0);
    check("r3_stored", ex_data2, 32'h0000_00AA);
    regwrite_wb = 0;
    step();
    check("r0_still_zero", ex_data1, 32'd0);

    regwrite_ex = 1; memtoreg_ex = 1; regaddr_ex = 5'd2;
    instr_id = enc_r(F_ADD, 5'd2, 5'd1, 5'd4, 5'd0);
    #1 check("lu_stall", {31'd0, stall_if}, 32'd1);
    step();
    check("lu_bubble", {31'd0, ex_valid}, 32'd0);
    regwrite_ex = 0; memtoreg_ex = 0; regaddr_ex = 0;
    regwrite_mem = 1; memtoreg_mem = 1; regaddr_mem = 5'd2;
    #1 check("lu_release", {31'd0, stall_if}, 32'd0);
    step();
    check("lu_issue", {31'd0, ex_valid}, 32'd1);

    regwrite_mem = 0; memtoreg_mem = 0; regaddr_mem = 0;
    valid_id = 0; regwrite_wb = 1; regaddr_wb = 5'd1; result_wb = 32'd7;
    step(); regaddr_wb = 5'd2;
    step(); regaddr_wb = 5'd8; result_wb = 32'd9;
    step(); regwrite_wb = 0;
    valid_id = 1; pc4_id = 32'h0000_0104; instr_id = enc_i(T_BEQ, 5'd1, 5'd2, 16'h0003);
    #1;
    check("beq_pcsrc", {31'd0, pcsrc}, 32'd1);
    check("beq_flush", {31'd0, flush_if}, 32'd1);
    check("beq_target", pc_target, 32'h0000_0110);
    step();
    instr_id = enc_i(T_BNE, 5'd1, 5'd2, 16'h0003);
    #1 check("bne_not_taken", {31'd0, pcsrc}, 32'd0);
    step();
    instr_id = enc_i(T_BEQ, 5'd6, 5'd8, 16'h0003);
    regwrite_mem = 1; regaddr_mem = 5'd6; aluout_mem = 32'd9;
    #1;
    check("fwd_no_stall", {31'd0, stall_if}, 32'd0);
    check("fwd_taken", {31'd0, pcsrc}, 32'd1);
    step();
    regwrite_mem = 0; regaddr_mem = 0; regwrite_ex = 1; regaddr_ex = 5'd6;
    #1;
    check("br_ex_stall", {31'd0, stall_if}, 32'd1);
    check("br_ex_hold", {31'd0, pcsrc}, 32'd0);
    step();
    check("br_bubble", {31'd0, ex_valid}, 32'd0);
    regwrite_ex = 0; regaddr_ex = 0; regwrite_mem = 1; regaddr_mem = 5'd6; aluout_mem = 32'd9;
    #1 check("br_resolve", {31'd0, pcsrc}, 32'd1);
    step();
    regwrite_mem = 0; regaddr_mem = 0;
    pc4_id = 32'h8000_0010; instr_id = {T_J, 26'h000_0040};
    #1;
    check("j_pcsrc", {31'd0, pcsrc}, 32'd1);
    check("j_target", pc_target, 32'h8000_0100);
    step();
    check("j_is_nop", {31'd0, ex_valid}, 32'd0);
`ifdef DECODE_PERF_CNT_EN
    check("perf_taken_lit", perf_taken, 32'd4);
    check("perf_stall_lit", perf_stall, 32'd2);
`endif

    regwrite_ex = 1; memtoreg_ex = 1; regaddr_ex = 5'd2;
    instr_id = enc_r(F_ADD, 5'd2, 5'd1, 5'd4, 5'd0);
    rst = 0;
    #1 check("rst_clears_stall", {31'd0, stall_if}, 32'd0);
    step();
    check("rst_zero_ex", {31'd0, ex_valid}, 32'd0);
    rst = 1; idle();

    for (int c = 0; c < 3000; c++) begin
      step();
      rst          = ($urandom_range(0, 49) != 0);
      valid_id     = ($urandom_range(0, 9) != 0);
      instr_id     = rand_instr();
      pc4_id       = $urandom();
      regaddr_ex   = 5'($urandom_range(0, 7));
      regaddr_mem  = 5'($urandom_range(0, 7));
      regaddr_wb   = 5'($urandom_range(0, 7));
      regwrite_ex  = ($urandom_range(0, 2) == 0);
      regwrite_mem = ($urandom_range(0, 2) == 0);
      regwrite_wb  = ($urandom_range(0, 1) == 0);
      memtoreg_ex  = ($urandom_range(0, 1) == 0);
      memtoreg_mem = ($urandom_range(0, 1) == 0);
      aluout_mem   = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 3));
      result_wb    = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 3));
    end
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
